// File: rtl/nave_ctrl.sv
// Ship controller: move-tick divider, horizontal ship motion and a single shot.
// The shot logic is built only when NAVE_TIRO_EN is defined.
module nave_ctrl #(
  parameter int SCREEN_W   = 640,
  parameter int X_INIT     = 270,
  parameter int Y_INIT     = 424,
  parameter int LARGURA    = 20,
  parameter int ALTURA     = 20,
  parameter int PASSO      = 8,
  parameter int TICK_DIV   = 833333,
  parameter int TIRO_PASSO = 4,
  parameter int TIRO_ALT   = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       direita,
  input  logic       esquerda,
  input  logic       disparo,
  input  logic       acerto,
  output logic [9:0] xNave,
  output logic [9:0] yNave,
  output logic [9:0] larguraNave,
  output logic [9:0] alturaNave,
  output logic [9:0] xTiro,
  output logic [9:0] yTiro,
  output logic       tiroAtivo,
  output logic       tick
);

  localparam int             CW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [9:0]     X_MAX   = 10'(SCREEN_W - LARGURA);
  localparam logic [9:0]     X_RST   = 10'(X_INIT);
  localparam logic [10:0]    PASSO_W = 11'(PASSO);
  localparam logic [9:0]     X_HALF  = 10'(LARGURA / 2);
  localparam logic [9:0]     Y_SHOT  = 10'(Y_INIT - TIRO_ALT);
  localparam logic [9:0]     TP_W    = 10'(TIRO_PASSO);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;
  logic [9:0]    x_q, x_d;
  logic [10:0]   sum_s;

  // Next-state for the divider and the ship position; motion only in a tick cycle.
  always_comb begin
    cnt_d = cnt_q;
    x_d   = x_q;
    sum_s = {1'b0, x_q} + PASSO_W;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    if (tick_q) begin
      if (direita && !esquerda) begin
        x_d = (sum_s > {1'b0, X_MAX}) ? X_MAX : sum_s[9:0];
      end else if (esquerda && !direita) begin
        x_d = (x_q >= PASSO_W[9:0]) ? (x_q - PASSO_W[9:0]) : 10'd0;
      end else begin
        x_d = x_q;
      end
    end else begin
      x_d = x_q;
    end
  end

  // tick_q is registered so it is high exactly while cnt_q sits at its last value.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      x_q    <= X_RST;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == CNT_MAX);
      x_q    <= x_d;
    end
  end

  assign tick        = tick_q;
  assign xNave       = x_q;
  assign yNave       = 10'(Y_INIT);
  assign larguraNave = 10'(LARGURA);
  assign alturaNave  = 10'(ALTURA);

`ifdef NAVE_TIRO_EN
  typedef enum logic {OCIOSO = 1'b0, ATIVO = 1'b1} estado_t;

  estado_t    estado_q;
  logic       pend_q;
  logic       disp_prev_q;
  logic [9:0] xt_q, yt_q;
  logic       rise_s;

  assign rise_s = disparo & ~disp_prev_q;

  // Shot FSM: a press is latched as pending and launched on the next tick;
  // a hit ends the flight immediately, taking priority over tick motion.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      pend_q      <= 1'b0;
      disp_prev_q <= 1'b0;
      xt_q        <= 10'd0;
      yt_q        <= 10'd0;
    end else begin
      disp_prev_q <= disparo;
      case (estado_q)
        OCIOSO: begin
          if (tick_q && pend_q) begin
            estado_q <= ATIVO;
            xt_q     <= x_q + X_HALF;
            yt_q     <= Y_SHOT;
            pend_q   <= 1'b0;
          end else if (rise_s) begin
            pend_q <= 1'b1;
          end else begin
            pend_q <= pend_q;
          end
        end
        ATIVO: begin
          if (acerto) begin
            estado_q <= OCIOSO;
          end else if (tick_q) begin
            if (yt_q < TP_W) begin
              estado_q <= OCIOSO;
            end else begin
              yt_q <= yt_q - TP_W;
            end
          end else begin
            estado_q <= ATIVO;
          end
        end
        default: begin
          estado_q <= OCIOSO;
          pend_q   <= 1'b0;
        end
      endcase
    end
  end

  assign tiroAtivo = (estado_q == ATIVO);
  assign xTiro     = xt_q;
  assign yTiro     = yt_q;
`else
  logic unused_shot_s;

  assign unused_shot_s = ^{disparo, acerto, X_HALF, Y_SHOT, TP_W};
  assign tiroAtivo     = 1'b0;
  assign xTiro         = 10'd0;
  assign yTiro         = 10'd0;
`endif

endmodule

// File: tb/tb_nave_ctrl.sv
// Bench for nave_ctrl with TICK_DIV=4: directed scenarios then random stimulus,
// all compared each cycle against a behavioural model of the ship and shot.
module tb_nave_ctrl;
  localparam int TD = 4;
`ifdef NAVE_TIRO_EN
  localparam bit SHOT = 1'b1;
`else
  localparam bit SHOT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, dir = 1'b0, esq = 1'b0, disp = 1'b0, ac = 1'b0;
  logic [9:0] x_nave, y_nave, l_nave, a_nave, x_tiro, y_tiro;
  logic       tiro_at, tk;

  int checks = 0;
  int errors = 0;

  int m_cnt = 0, m_x = 270, m_xt = 0, m_yt = 0;
  bit m_on = 1'b0, m_pend = 1'b0, m_prev = 1'b0;
  int saved_y;

  nave_ctrl #(.TICK_DIV(TD)) dut (
    .CLOCK_50(clk), .reset(rst), .direita(dir), .esquerda(esq),
    .disparo(disp), .acerto(ac),
    .xNave(x_nave), .yNave(y_nave), .larguraNave(l_nave), .alturaNave(a_nave),
    .xTiro(x_tiro), .yTiro(y_tiro), .tiroAtivo(tiro_at), .tick(tk)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit t, rise;
    int x_old;
    if (rst) begin
      m_cnt = 0; m_x = 270; m_xt = 0; m_yt = 0;
      m_on = 1'b0; m_pend = 1'b0; m_prev = 1'b0;
    end else begin
      t = (m_cnt == TD - 1);
      x_old = m_x;
      if (t && dir && !esq) m_x = (m_x + 8 > 620) ? 620 : m_x + 8;
      else if (t && esq && !dir) m_x = (m_x >= 8) ? m_x - 8 : 0;
      if (SHOT) begin
        rise = disp && !m_prev;
        if (m_on) begin
          if (ac) m_on = 1'b0;
          else if (t) begin
            if (m_yt < 4) m_on = 1'b0;
            else m_yt = m_yt - 4;
          end
        end else begin
          if (t && m_pend) begin
            m_on = 1'b1; m_xt = x_old + 10; m_yt = 424 - 8; m_pend = 1'b0;
          end else if (rise) m_pend = 1'b1;
        end
      end
      m_prev = disp;
      m_cnt = (m_cnt + 1) % TD;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("tick", tk, (m_cnt == TD - 1));
    chk("xNave", x_nave, m_x);
    chk("yNave", y_nave, 424);
    chk("larguraNave", l_nave, 20);
    chk("alturaNave", a_nave, 20);
    chk("tiroAtivo", tiro_at, m_on);
    chk("xTiro", x_tiro, m_xt);
    chk("yTiro", y_tiro, m_yt);
  endtask

  task automatic do_reset();
    rst = 1'b1; dir = 1'b0; esq = 1'b0; disp = 1'b0; ac = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset and idle: ship at 270, tick every 4th cycle.
    do_reset();
    chk("reset_x", x_nave, 270);
    chk("reset_tick", tk, 0);
    chk("reset_tiro", tiro_at, 0);
    repeat (12) step();
    chk("idle_x", x_nave, 270);

    // Right to saturation, then left to zero.
    dir = 1'b1;
    repeat (50 * TD) step();
    chk("sat_right", x_nave, 620);
    dir = 1'b0; esq = 1'b1;
    repeat (82 * TD) step();
    chk("sat_left", x_nave, 0);
    esq = 1'b0;

    // Both pressed: no motion.
    do_reset();
    dir = 1'b1; esq = 1'b1;
    repeat (5 * TD) step();
    chk("both_hold", x_nave, 270);
    dir = 1'b0; esq = 1'b0;

    // Fire from x=270 and follow the full flight.
    do_reset();
    disp = 1'b1; step(); disp = 1'b0;
    for (int i = 0; i < 3 * TD && tiro_at !== 1'b1; i++) step();
    chk("fire_active", tiro_at, SHOT);
    chk("fire_x", x_tiro, SHOT ? 280 : 0);
    chk("fire_y", y_tiro, SHOT ? 416 : 0);
    for (int i = 0; i < 120 * TD && tiro_at !== 1'b0; i++) step();
    chk("flight_end", tiro_at, 0);

    // Hit coinciding with a tick, fire button held throughout.
    disp = 1'b1; step(); disp = 1'b0;
    for (int i = 0; i < 3 * TD && tiro_at !== 1'b1; i++) step();
    disp = 1'b1;
    repeat (3 * TD) step();
    for (int i = 0; i < TD && m_cnt != TD - 1; i++) step();
    saved_y = int'(y_tiro);
    ac = 1'b1; step(); ac = 1'b0;
    chk("hit_off", tiro_at, 0);
    chk("hit_y_hold", y_tiro, saved_y);
    repeat (10 * TD) step();
    chk("held_no_refire", tiro_at, 0);
    disp = 1'b0; step(); disp = 1'b1;
    repeat (2 * TD) step();
    chk("refire", tiro_at, SHOT);

    // Reset in the middle of a flight.
    rst = 1'b1; step(); rst = 1'b0; disp = 1'b0;
    chk("midreset_tiro", tiro_at, 0);
    chk("midreset_xt", x_tiro, 0);
    chk("midreset_yt", y_tiro, 0);
    chk("midreset_x", x_nave, 270);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0) dir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) esq = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) disp = ~disp;
      ac = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
